// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
//   Arbitrates the single-port main work RAM between the Z80 and the
//   high-score save/restore engine. The high-score side owns the port only
//   while the core is paused, after a settle window that lets the CPU finish
//   a last write.
//
// Ports
//   clk48M, reset           core clock, synchronous active-high reset
//   PAUSE_N                 low = CPU halted, high-score access allowed
//   cpu_ad/cpu_do/cpu_we    CPU work-RAM request (address already decoded)
//   cpu_di                  CPU read data (straight from ram_do)
//   HSAD/HSDI/HSWE          high-score request in CPU address space
//   HSDO                    high-score read data, registered
//   ram_ad/ram_di/ram_we    work-RAM port
//   ram_do                  work-RAM read data, one cycle after ram_ad
//   hs_grant                high-score side owns the RAM port
//   hs_drop                 sticky: a high-score write came in while not granted
module hiscore_ram_port #(
    parameter int          RAM_AW = 12,
    parameter logic [15:0] BASE   = 16'hC000,
    parameter int          SETTLE = 4
) (
    input  logic              clk48M,
    input  logic              reset,
    input  logic              PAUSE_N,
    input  logic [RAM_AW-1:0] cpu_ad,
    input  logic [7:0]        cpu_do,
    input  logic              cpu_we,
    output logic [7:0]        cpu_di,
    input  logic [15:0]       HSAD,
    input  logic [7:0]        HSDI,
    input  logic              HSWE,
    output logic [7:0]        HSDO,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    input  logic [7:0]        ram_do,
    output logic              hs_grant,
    output logic              hs_drop
);

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HS     = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       hit;
    logic       hit_d;

    // High-score address falls inside the work-RAM window.
    assign hit = (HSAD[15:RAM_AW] == BASE[15:RAM_AW]);

    // CPU read path is untouched: same one-cycle RAM latency.
    assign cpu_di = ram_do;

    // Port mux is selected by the registered state only, so PAUSE_N never
    // reaches the RAM port combinationally. In HS the CPU strobe is ignored,
    // which is what makes a simultaneous high-score write win.
    always_comb begin
        ram_ad = cpu_ad;
        ram_di = cpu_do;
        ram_we = cpu_we;
        if (state == ST_HS) begin
            ram_ad = HSAD[RAM_AW-1:0];
            ram_di = HSDI;
            ram_we = HSWE & hit;
        end
        // A reset cycle never writes, even with a strobe still held.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            state      <= ST_CPU;
            settle_cnt <= '0;
            hs_grant   <= 1'b0;
            hs_drop    <= 1'b0;
            hit_d      <= 1'b0;
            HSDO       <= 8'h00;
        end else begin
            // hit_d lines up with ram_do; misses and ungranted cycles read 0.
            hit_d <= (state == ST_HS) && hit;
            HSDO  <= hit_d ? ram_do : 8'h00;

            if (HSWE && (state != ST_HS)) begin
                hs_drop <= 1'b1;
            end

            case (state)
                ST_CPU: begin
                    if (!PAUSE_N) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (PAUSE_N) begin
                        state <= ST_CPU;
                    end else if (settle_cnt == 4'd0) begin
                        state    <= ST_HS;
                        hs_grant <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_HS: begin
                    if (PAUSE_N) begin
                        state    <= ST_CPU;
                        hs_grant <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_CPU;
                    hs_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_ram_port.sv
module tb_hiscore_ram_port;

    localparam int          RAM_AW = 12;
    localparam logic [15:0] BASE   = 16'hC000;
    localparam int          SETTLE = 4;

    logic              clk48M = 1'b0;
    logic              reset;
    logic              PAUSE_N;
    logic [RAM_AW-1:0] cpu_ad;
    logic [7:0]        cpu_do;
    logic              cpu_we;
    logic [7:0]        cpu_di;
    logic [15:0]       HSAD;
    logic [7:0]        HSDI;
    logic              HSWE;
    logic [7:0]        HSDO;
    logic [RAM_AW-1:0] ram_ad;
    logic [7:0]        ram_di;
    logic              ram_we;
    logic [7:0]        ram_do;
    logic              hs_grant;
    logic              hs_drop;

    hiscore_ram_port #(.RAM_AW(RAM_AW), .BASE(BASE), .SETTLE(SETTLE)) dut (
        .clk48M(clk48M), .reset(reset), .PAUSE_N(PAUSE_N),
        .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di),
        .HSAD(HSAD), .HSDI(HSDI), .HSWE(HSWE), .HSDO(HSDO),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
        .hs_grant(hs_grant), .hs_drop(hs_drop)
    );

    always #5 clk48M = ~clk48M;

    // Work RAM: single port, synchronous read.
    logic [7:0] ram [0:(1<<RAM_AW)-1];
    always @(posedge clk48M) begin
        if (ram_we) ram[ram_ad] <= ram_di;
        ram_do <= ram[ram_ad];
    end

    // Reference model: expected RAM contents plus the number of consecutive
    // clock edges on which the core has been seen paused (out of reset).
    logic [7:0]        exp_mem [0:(1<<RAM_AW)-1];
    int                low_run = 0;
    int                checks  = 0;
    int                errors  = 0;
    logic [RAM_AW-1:0] addrs [0:7];
    logic [RAM_AW-1:0] a;
    logic [7:0]        d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one edge; update the pause-run model and check grant every cycle.
    task automatic tick();
        @(posedge clk48M);
        if (reset || PAUSE_N) low_run = 0;
        else                  low_run++;
        #1;
        chk("grant", {31'd0, hs_grant}, {31'd0, (low_run >= SETTLE + 1)});
    endtask

    task automatic hs_write(input logic [RAM_AW-1:0] wa, input logic [7:0] wd);
        HSAD = BASE | 16'(wa); HSDI = wd; HSWE = 1'b1;
        tick();
        HSWE = 1'b0;
        exp_mem[wa] = wd;
    endtask

    task automatic hs_read(input logic [15:0] ra, input logic [7:0] expv, input string tag);
        HSAD = ra;
        tick();
        tick();
        chk(tag, {24'd0, HSDO}, {24'd0, expv});
    endtask

    initial begin
        reset = 1'b1; PAUSE_N = 1'b1;
        cpu_ad = '0; cpu_do = '0; cpu_we = 1'b0;
        HSAD = '0; HSDI = '0; HSWE = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_hsdo", {24'd0, HSDO}, 32'h0);
        chk("rst_drop", {31'd0, hs_drop}, 32'h0);
        chk("rst_we",   {31'd0, ram_we}, 32'h0);

        // CPU path: writes then read-backs, one-cycle read latency.
        for (int i = 0; i < 8; i++) begin
            addrs[i] = (i == 0) ? 12'h010 : RAM_AW'($urandom);
            if (i == 1) addrs[i] = 12'h123;
            for (int j = 0; j < i; j++)
                if (addrs[j] == addrs[i]) addrs[i] = addrs[i] + 12'h200;
            d = (i == 0) ? 8'h5A : 8'($urandom_range(1, 255));
            cpu_ad = addrs[i]; cpu_do = d; cpu_we = 1'b1;
            tick();
            cpu_we = 1'b0;
            exp_mem[addrs[i]] = d;
        end
        for (int i = 0; i < 8; i++) begin
            cpu_ad = addrs[i];
            tick();
            chk("cpu_rd", {24'd0, cpu_di}, {24'd0, exp_mem[addrs[i]]});
        end

        // Premature high-score write: dropped, flag sticks.
        HSAD = BASE | 16'(addrs[2]); HSDI = ~exp_mem[addrs[2]]; HSWE = 1'b1;
        tick();
        HSWE = 1'b0;
        tick();
        chk("drop_set", {31'd0, hs_drop}, 32'h1);
        chk("drop_mem", {24'd0, ram[addrs[2]]}, {24'd0, exp_mem[addrs[2]]});
        for (int i = 0; i < 3; i++) tick();
        chk("drop_sticky", {31'd0, hs_drop}, 32'h1);

        // Abort from SETTLE: grant never appears (checked every tick).
        PAUSE_N = 1'b0;
        tick();
        tick();
        PAUSE_N = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Grant sequence with a late CPU write two cycles after the pause.
        PAUSE_N = 1'b0;
        tick();
        tick();
        a = addrs[3]; d = 8'($urandom_range(1, 255));
        cpu_ad = a; cpu_do = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        exp_mem[a] = d;
        tick();
        chk("pre_grant", {31'd0, hs_grant}, 32'h0);
        tick();
        chk("grant_up", {31'd0, hs_grant}, 32'h1);
        chk("late_cpu_wr", {24'd0, ram[a]}, {24'd0, exp_mem[a]});

        // High-score restore: fixed vector, then random writes with a
        // colliding CPU write that must lose.
        hs_write(12'h123, 8'hA5);
        hs_read(16'hC123, 8'hA5, "hs_rd_c123");
        chk("ram_123", {24'd0, ram[12'h123]}, 32'hA5);
        for (int i = 0; i < 6; i++) begin
            a = RAM_AW'($urandom);
            d = 8'($urandom);
            cpu_ad = a; cpu_do = ~d; cpu_we = 1'b1;
            hs_write(a, d);
            cpu_we = 1'b0;
            hs_read(BASE | 16'(a), exp_mem[a], "hs_rd_rand");
        end
        hs_read(BASE | 16'(addrs[4]), exp_mem[addrs[4]], "hs_rd_cpudata");

        // Out-of-window accesses: no write strobe, reads return zero.
        hs_write(12'h000, 8'h3C);
        HSAD = 16'hD000; HSDI = 8'h77; HSWE = 1'b1;
        #1;
        chk("miss_we", {31'd0, ram_we}, 32'h0);
        tick();
        HSWE = 1'b0;
        chk("miss_mem", {24'd0, ram[12'h000]}, 32'h3C);
        hs_read(16'hD000, 8'h00, "miss_rd");
        for (int i = 0; i < 4; i++) begin
            HSAD = {4'($urandom_range(0, 11)), 12'($urandom)};
            hs_read(HSAD, 8'h00, "miss_rd_rand");
        end

        // Release with a write in the same cycle: it still commits.
        a = addrs[5]; d = ~exp_mem[a];
        HSAD = BASE | 16'(a); HSDI = d; HSWE = 1'b1; PAUSE_N = 1'b1;
        tick();
        HSWE = 1'b0;
        exp_mem[a] = d;
        tick();
        chk("release_wr", {24'd0, ram[a]}, {24'd0, exp_mem[a]});
        cpu_ad = a;
        tick();
        chk("release_cpu_rd", {24'd0, cpu_di}, {24'd0, exp_mem[a]});

        // Reset in the middle of HS with HSWE held.
        PAUSE_N = 1'b0;
        for (int i = 0; i < SETTLE + 1; i++) tick();
        hs_read(BASE | 16'(addrs[6]), exp_mem[addrs[6]], "pre_rst_rd");
        a = addrs[6];
        HSAD = BASE | 16'(a); HSDI = exp_mem[a]; HSWE = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; PAUSE_N = 1'b1;
        #1;
        chk("rst_hs_we",   {31'd0, ram_we}, 32'h0);
        chk("rst_hs_hsdo", {24'd0, HSDO}, 32'h0);
        chk("rst_hs_drop", {31'd0, hs_drop}, 32'h0);
        HSWE = 1'b0;
        tick();
        chk("rst_mem", {24'd0, ram[a]}, {24'd0, exp_mem[a]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
